audio_tdm_serializer: RTL and testbench

//  Parametrised audio DAC serializer; successor to the fixed stereo path in sound_gen.

---
 rtl/audio_tdm_serializer.sv | 199 +++++++++++++++++++
 tb/tb_audio_tdm_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tdm_serializer.sv
// ---------------------------------------------------------------------------
// audio_tdm_serializer
//
// Audio DAC serializer for a parametrised number of channels. One frame of
// NUM_CH samples is accepted per valid/ready handshake into a holding register.
// At each frame boundary the frame moves into a shift register. It is then sent
// MSB-first as bit clock, LR/frame clock and serial data. Both left-justified
// (FORMAT=0) and I2S (FORMAT=1, data one bit period late) framing are supported.
// Each slot is SLOT_W bits wide: the sample followed by zero padding.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       run the serializer; low = idle, counters and line outputs at 0
//   in_data      one frame, channel 0 in the MSBs (NUM_CH*SAMPLE_W bits)
//   in_valid     in_data valid
//   in_ready     holding register empty
//   aud_bclk     bit clock (BCLK_DIV clk cycles per bit)
//   aud_daclrck  LR/frame clock, high for the upper half of the slots
//   aud_dacdat   serial data, changes while aud_bclk is low
//   frame_start  one-cycle pulse on the first cycle of each frame
//   underrun     one-cycle pulse: a frame started with no data available
//
// All line outputs are registered from the counter state of the cycle before.
// aud_bclk, aud_daclrck, aud_dacdat, frame_start and underrun therefore stay
// mutually aligned. frame_start is seen together with bclk=0, lrck=0 and the
// first bit of the new frame.
// ---------------------------------------------------------------------------
module audio_tdm_serializer #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 2,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 4,
  parameter int FORMAT   = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       aud_bclk,
  output logic                       aud_daclrck,
  output logic                       aud_dacdat,
  output logic                       frame_start,
  output logic                       underrun
);

  localparam int IN_W    = NUM_CH * SAMPLE_W;
  localparam int FRAME_W = NUM_CH * SLOT_W;
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W   = (SLOT_W > 1)   ? $clog2(SLOT_W)   : 1;
  localparam int SLOT_CW = (NUM_CH > 1)   ? $clog2(NUM_CH)   : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF  = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(SLOT_W - 1);
  localparam logic [SLOT_CW-1:0] SLOT_LAST = SLOT_CW'(NUM_CH - 1);
  localparam logic [SLOT_CW-1:0] SLOT_HALF = SLOT_CW'(NUM_CH / 2);

  // Counters
  logic [DIV_W-1:0]   div_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [SLOT_CW-1:0] slot_q;

  // Buffering
  logic [IN_W-1:0]    hold_q;
  logic               hold_full_q;
  logic [FRAME_W-1:0] shift_q;
  logic               dly_q;

  // Next-state / decode
  logic               boundary;
  logic               bit_start;
  logic               div_wrap;
  logic               bit_wrap;
  logic               slot_wrap;
  logic [IN_W-1:0]    load_src;
  logic [FRAME_W-1:0] load_frame;
  logic [FRAME_W-1:0] shift_nxt;
  logic               dly_nxt;
  logic               dat_nxt;

  assign in_ready  = ~hold_full_q;

  assign bit_start = (div_q == '0);
  assign div_wrap  = (div_q == DIV_LAST);
  assign bit_wrap  = (bit_cnt_q == BIT_LAST);
  assign slot_wrap = (slot_q == SLOT_LAST);
  assign boundary  = enable && bit_start && (bit_cnt_q == '0) && (slot_q == '0);

  // Source for the next frame: the holding register if full. Otherwise the
  // input bus in the same cycle (bypass). Otherwise silence.
  assign load_src = hold_full_q ? hold_q : (in_valid ? in_data : '0);

  // Spread the packed samples into SLOT_W-wide slots, sample MSB-aligned
  // in each slot with zero padding after its LSB.
  always_comb begin
    load_frame = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      load_frame[(NUM_CH - 1 - k) * SLOT_W + (SLOT_W - SAMPLE_W) +: SAMPLE_W] =
        load_src[(NUM_CH - 1 - k) * SAMPLE_W +: SAMPLE_W];
    end
  end

  // shift_q[MSB] is always the bit of the current bit period. The register
  // advances on the first clk cycle of every bit period except the first of a
  // frame, where the new frame is loaded instead.
  always_comb begin
    shift_nxt = shift_q;
    if (!enable) begin
      shift_nxt = '0;
    end else if (boundary) begin
      shift_nxt = load_frame;
    end else if (bit_start) begin
      shift_nxt = {shift_q[FRAME_W-2:0], 1'b0};
    end
  end

  // I2S delay: on each bit start, capture the bit that was on the line
  // during the period just ending. The last bit of a frame therefore spills
  // into bit 0 of the next frame.
  always_comb begin
    dly_nxt = dly_q;
    if (!enable) begin
      dly_nxt = 1'b0;
    end else if (bit_start) begin
      dly_nxt = shift_q[FRAME_W-1];
    end
  end

  always_comb begin
    dat_nxt = 1'b0;
    if (enable) begin
      dat_nxt = (FORMAT == 1) ? dly_nxt : shift_nxt[FRAME_W-1];
    end
  end

  // Bit / slot timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      slot_q    <= '0;
    end else if (!enable) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      slot_q    <= '0;
    end else if (div_wrap) begin
      div_q <= '0;
      if (bit_wrap) begin
        bit_cnt_q <= '0;
        slot_q    <= slot_wrap ? '0 : slot_q + SLOT_CW'(1);
      end else begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Holding register. This stays live while disabled. At a boundary it is
  // drained into the shift register. An empty holding register is never
  // written at a boundary, because a frame offered then goes straight to the
  // shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (boundary) begin
      hold_full_q <= 1'b0;
    end else if (in_valid && !hold_full_q) begin
      hold_q      <= in_data;
      hold_full_q <= 1'b1;
    end
  end

  // Shift / delay state and registered line outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      dly_q       <= 1'b0;
      aud_bclk    <= 1'b0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      shift_q     <= shift_nxt;
      dly_q       <= dly_nxt;
      aud_bclk    <= enable && (div_q >= DIV_HALF);
      aud_daclrck <= enable && (slot_q >= SLOT_HALF);
      aud_dacdat  <= dat_nxt;
      frame_start <= boundary;
      underrun    <= boundary && !hold_full_q && !in_valid;
    end
  end

endmodule

// File: tb/tb_audio_tdm_serializer.sv
// ---------------------------------------------------------------------------
// tb_audio_tdm_serializer
//
// Three instances:
//   dut_a  defaults, left-justified
//   dut_b  defaults, I2S; driven with the same stimulus as dut_a
//   dut_c  4 channels, 24-bit slots, 20-bit samples, BCLK_DIV=2
// The serial words are sampled on aud_bclk rising edges, as seen at negedge clk.
// ---------------------------------------------------------------------------
module tb_audio_tdm_serializer;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        enable_ab;
  logic [31:0] in_data_ab;
  logic        in_valid_ab;
  logic        in_ready_a, bclk_a, lrck_a, dat_a, fs_a, ur_a;
  logic        in_ready_b, bclk_b, lrck_b, dat_b, fs_b, ur_b;

  logic        enable_c;
  logic [79:0] in_data_c;
  logic        in_valid_c;
  logic        in_ready_c, bclk_c, lrck_c, dat_c, fs_c, ur_c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  audio_tdm_serializer #(.FORMAT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable_ab),
    .in_data(in_data_ab), .in_valid(in_valid_ab), .in_ready(in_ready_a),
    .aud_bclk(bclk_a), .aud_daclrck(lrck_a), .aud_dacdat(dat_a),
    .frame_start(fs_a), .underrun(ur_a)
  );

  audio_tdm_serializer #(.FORMAT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable_ab),
    .in_data(in_data_ab), .in_valid(in_valid_ab), .in_ready(in_ready_b),
    .aud_bclk(bclk_b), .aud_daclrck(lrck_b), .aud_dacdat(dat_b),
    .frame_start(fs_b), .underrun(ur_b)
  );

  audio_tdm_serializer #(
    .SAMPLE_W(20), .NUM_CH(4), .SLOT_W(24), .BCLK_DIV(2), .FORMAT(0)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(enable_c),
    .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .aud_bclk(bclk_c), .aud_daclrck(lrck_c), .aud_dacdat(dat_c),
    .frame_start(fs_c), .underrun(ur_c)
  );

  typedef struct {
    bit          valid;     // a frame is offered for this row
    int          feed_cyc;  // cycle of the previous frame it is offered in (127 = bypass)
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_dat;   // expected left-justified serial word
    bit          exp_ur;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at the negedge where frame_start is expected. It runs one whole
  // 128-cycle frame on dut_a/dut_b, optionally offers the next frame at cycle
  // nxt_cyc, and returns at the next frame's first cycle.
  task automatic cap_ab(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b,
                        input bit exp_ur, input bit nxt_feed, input int nxt_cyc,
                        input logic [31:0] nxt_data);
    logic [31:0] da, db, lr;
    int rises, lr_hi, extra;
    logic pa;
    da = '0; db = '0; lr = '0; rises = 0; lr_hi = 0; extra = 0; pa = 1'b0;
    for (int c = 0; c < 128; c++) begin
      in_valid_ab = nxt_feed && (c == nxt_cyc);
      if (nxt_feed && c == nxt_cyc) in_data_ab = nxt_data;
      if (c == 0) begin
        chk({tag, "_fs_a"}, 96'(fs_a), 96'd1);
        chk({tag, "_fs_b"}, 96'(fs_b), 96'd1);
        chk({tag, "_ur_a"}, 96'(ur_a), 96'(exp_ur));
        chk({tag, "_ur_b"}, 96'(ur_b), 96'(exp_ur));
        chk({tag, "_ready0"}, 96'(in_ready_a), 96'd1);
      end else begin
        if (fs_a || fs_b || ur_a || ur_b) extra++;
        if (bclk_a && !pa) begin
          rises++;
          da = {da[30:0], dat_a};
          db = {db[30:0], dat_b};
          lr = {lr[30:0], lrck_a};
        end
      end
      if (lrck_a) lr_hi++;
      pa = bclk_a;
      if (nxt_feed && nxt_cyc < 127 && c == nxt_cyc + 1)
        chk({tag, "_ready_held"}, 96'(in_ready_a), 96'd0);
      @(negedge clk);
    end
    in_valid_ab = 1'b0;
    chk({tag, "_dat_a"}, 96'(da), 96'(exp_a));
    chk({tag, "_dat_b"}, 96'(db), 96'(exp_b));
    chk({tag, "_lrck"}, 96'(lr), 96'h0000_FFFF);
    chk({tag, "_rises"}, 96'(rises), 96'd32);
    chk({tag, "_lrck_hi"}, 96'(lr_hi), 96'd64);
    chk({tag, "_extra_pulse"}, 96'(extra), 96'd0);
  endtask

  // One 192-cycle frame on dut_c, starting at the negedge where frame_start is expected.
  task automatic cap_c(input string tag, input logic [95:0] exp_dat, input bit exp_ur);
    logic [95:0] d, lr;
    int rises, lr_hi, extra;
    logic pa;
    d = '0; lr = '0; rises = 0; lr_hi = 0; extra = 0; pa = 1'b0;
    for (int c = 0; c < 192; c++) begin
      if (c == 0) begin
        chk({tag, "_fs"}, 96'(fs_c), 96'd1);
        chk({tag, "_ur"}, 96'(ur_c), 96'(exp_ur));
      end else begin
        if (fs_c || ur_c) extra++;
        if (bclk_c && !pa) begin
          rises++;
          d  = {d[94:0], dat_c};
          lr = {lr[94:0], lrck_c};
        end
      end
      if (lrck_c) lr_hi++;
      pa = bclk_c;
      @(negedge clk);
    end
    chk({tag, "_dat"}, d, exp_dat);
    chk({tag, "_lrck"}, lr, {48'h0, 48'hFFFF_FFFF_FFFF});
    chk({tag, "_rises"}, 96'(rises), 96'd96);
    chk({tag, "_lrck_hi"}, 96'(lr_hi), 96'd96);
    chk({tag, "_extra_pulse"}, 96'(extra), 96'd0);
  endtask

  initial begin
    logic prev_last;
    logic [31:0] exp_b;
    string tag;

    vecs[0] = '{1'b1,   0, 16'hA5F0, 16'h0001, 32'hA5F0_0001, 1'b0};
    vecs[1] = '{1'b1,   8, 16'h1234, 16'hFEDC, 32'h1234_FEDC, 1'b0};
    vecs[2] = '{1'b0,   0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b1, 127, 16'h8000, 16'h8001, 32'h8000_8001, 1'b0};
    vecs[4] = '{1'b1,   8, 16'hFFFF, 16'h8000, 32'hFFFF_8000, 1'b0};
    vecs[5] = '{1'b0,   0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0,   0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};

    reset_n = 1'b0; enable_ab = 1'b0; in_valid_ab = 1'b0; in_data_ab = '0;
    enable_c = 1'b0; in_valid_c = 1'b0; in_data_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", 96'(in_ready_a), 96'd1);
    chk("rst_outs_a", 96'({bclk_a, lrck_a, dat_a, fs_a, ur_a}), 96'd0);
    chk("rst_outs_b", 96'({bclk_b, lrck_b, dat_b, fs_b, ur_b}), 96'd0);
    chk("rst_ready_c", 96'(in_ready_c), 96'd1);
    chk("rst_outs_c", 96'({bclk_c, lrck_c, dat_c, fs_c, ur_c}), 96'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // First frame is offered while idle; the handshake works while disabled.
    in_data_ab = {vecs[0].l, vecs[0].r}; in_valid_ab = 1'b1;
    @(negedge clk);
    in_valid_ab = 1'b0;
    chk("idle_hold_full", 96'(in_ready_a), 96'd0);
    chk("idle_outs_a", 96'({bclk_a, lrck_a, dat_a, fs_a, ur_a}), 96'd0);
    enable_ab = 1'b1;
    @(negedge clk);

    prev_last = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("row%0d", i);
      exp_b = {prev_last, vecs[i].exp_dat[31:1]};
      if (i < 6)
        cap_ab(tag, vecs[i].exp_dat, exp_b, vecs[i].exp_ur, vecs[i+1].valid,
               vecs[i+1].feed_cyc, {vecs[i+1].l, vecs[i+1].r});
      else
        cap_ab(tag, vecs[i].exp_dat, exp_b, vecs[i].exp_ur, 1'b0, 0, 32'h0);
      prev_last = vecs[i].exp_dat[0];
    end

    // Start of an underrun frame; offer a frame, then drop enable at bit 7 of slot 0.
    chk("tail_fs", 96'(fs_a), 96'd1);
    chk("tail_ur", 96'(ur_a), 96'd1);
    in_data_ab = 32'hC3A5_5A3C; in_valid_ab = 1'b1;
    @(negedge clk);
    in_valid_ab = 1'b0;
    repeat (28) @(negedge clk);
    enable_ab = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("off%0d_a", k), 96'({bclk_a, lrck_a, dat_a, fs_a, ur_a}), 96'd0);
      chk($sformatf("off%0d_b", k), 96'({bclk_b, lrck_b, dat_b, fs_b, ur_b}), 96'd0);
      chk($sformatf("off%0d_hold", k), 96'(in_ready_a), 96'd0);
    end
    enable_ab = 1'b1;
    @(negedge clk);
    cap_ab("reen", 32'hC3A5_5A3C, 32'h61D2_AD1E, 1'b0, 1'b0, 0, 32'h0);

    // Reset mid-frame drops the pending frame.
    in_data_ab = 32'h1111_2222; in_valid_ab = 1'b1;
    @(negedge clk);
    in_valid_ab = 1'b0;
    chk("pre_rst_hold", 96'(in_ready_a), 96'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 96'(in_ready_a), 96'd1);
    chk("midrst_outs", 96'({bclk_a, lrck_a, dat_a, fs_a, ur_a}), 96'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_fs", 96'(fs_a), 96'd1);
    chk("postrst_ur", 96'(ur_a), 96'd1);
    enable_ab = 1'b0;

    // Four-channel TDM with slot padding.
    in_data_c = {20'hABCDE, 20'h12345, 20'hFFFFF, 20'h80001}; in_valid_c = 1'b1;
    @(negedge clk);
    in_valid_c = 1'b0;
    chk("c_hold_full", 96'(in_ready_c), 96'd0);
    enable_c = 1'b1;
    @(negedge clk);
    cap_c("c0", {20'hABCDE, 4'h0, 20'h12345, 4'h0, 20'hFFFFF, 4'h0, 20'h80001, 4'h0}, 1'b0);
    cap_c("c1", 96'h0, 1'b1);
    enable_c = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
